// File: rtl/upc_display_sequencer.sv
// Sequencer for the UPC seven-segment datapath: it passes the switch code through in MANUAL,
// or steps through the codes automatically with a dwell time, a blanking gap, pause and single-step.
module upc_display_sequencer #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int BLANK_CYCLES = 5_000_000,
    parameter int NUM_CODES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw_upc,
    input  logic       auto_en,
    input  logic       pause,
    input  logic       step,
    output logic [2:0] upc,
    output logic       blank,
    output logic       auto_active,
    output logic       wrap
);
    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] DWELL_FULL = TW'(DWELL_CYCLES);
    localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_CODES - 1);

    typedef enum logic [1:0] {MANUAL, SHOW, GAP, HOLD} state_t;

    state_t        state_reg, state_next;
    logic [2:0]    idx_reg, idx_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [2:0]    upc_reg;
    logic          blank_reg, active_reg, wrap_reg;
    logic          advance;
    logic          idx_at_last;

    assign idx_at_last = (idx_reg == IDX_LAST);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        timer_next = timer_reg;
        advance    = 1'b0;
        case (state_reg)
            MANUAL: begin
                if (auto_en) begin
                    state_next = SHOW;
                    idx_next   = 3'd0;
                    timer_next = '0;
                end
            end
            SHOW: begin
                if (!auto_en) begin
                    state_next = MANUAL;
                end else if (pause) begin
                    // The cycle in which pause is seen still counts towards the dwell.
                    state_next = HOLD;
                    timer_next = timer_reg + 1'b1;
                end else if (timer_reg == DWELL_LAST) begin
                    timer_next = '0;
                    if (BLANK_CYCLES > 0) state_next = GAP;
                    else                  advance    = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            GAP: begin
                if (!auto_en) begin
                    state_next = MANUAL;
                end else if (timer_reg == BLANK_LAST) begin
                    advance    = 1'b1;
                    timer_next = '0;
                    state_next = SHOW;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            HOLD: begin
                if (!auto_en) begin
                    state_next = MANUAL;
                end else if (pause) begin
                    if (step) begin
                        advance    = 1'b1;
                        timer_next = '0;
                    end
                end else if (step) begin
                    advance    = 1'b1;
                    timer_next = '0;
                    state_next = SHOW;
                end else if (timer_reg >= DWELL_FULL) begin
                    // Paused on the final dwell cycle: nothing left to show, so expire now.
                    timer_next = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_next = GAP;
                    end else begin
                        advance    = 1'b1;
                        state_next = SHOW;
                    end
                end else begin
                    state_next = SHOW;
                end
            end
            default: state_next = MANUAL;
        endcase
        if (advance) idx_next = idx_at_last ? 3'd0 : idx_reg + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= MANUAL;
            idx_reg    <= 3'd0;
            timer_reg  <= '0;
            upc_reg    <= 3'd0;
            blank_reg  <= 1'b0;
            active_reg <= 1'b0;
            wrap_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            timer_reg  <= timer_next;
            upc_reg    <= (state_next == MANUAL) ? sw_upc : idx_next;
            blank_reg  <= (state_next == GAP);
            active_reg <= (state_next != MANUAL);
            wrap_reg   <= advance && idx_at_last;
        end
    end

    assign upc         = upc_reg;
    assign blank       = blank_reg;
    assign auto_active = active_reg;
    assign wrap        = wrap_reg;
endmodule

// File: tb/tb_upc_display_sequencer.sv
// Directed bench for upc_display_sequencer with DWELL=4, BLANK=2, NUM_CODES=8.
module tb_upc_display_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] sw_upc;
    logic       auto_en, pause, step;
    logic [2:0] upc;
    logic       blank, auto_active, wrap;

    int checks = 0;
    int errors = 0;

    upc_display_sequencer #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .NUM_CODES(8)) dut (
        .clk(clk), .reset(reset), .sw_upc(sw_upc), .auto_en(auto_en), .pause(pause),
        .step(step), .upc(upc), .blank(blank), .auto_active(auto_active), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       auto_en;
        logic [2:0] sw;
        logic [2:0] upc;
        logic       blank;
        logic       active;
        logic       wrap;
    } vec_t;

    vec_t vecs[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] e_upc, input logic e_blank,
                         input logic e_active, input logic e_wrap);
        checks++;
        if (upc !== e_upc || blank !== e_blank || auto_active !== e_active || wrap !== e_wrap) begin
            errors++;
            $display("FAIL %s: got upc=%0d blank=%b active=%b wrap=%b, expected upc=%0d blank=%b active=%b wrap=%b",
                     name, upc, blank, auto_active, wrap, e_upc, e_blank, e_active, e_wrap);
        end else begin
            $display("ok   %s: upc=%0d blank=%b active=%b wrap=%b", name, upc, blank, auto_active, wrap);
        end
    endtask

    initial begin
        // Manual pass-through, then the first two codes of AUTO (4 shown + 2 blanked each).
        vecs[0]  = '{1'b0, 3'd5, 3'd5, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 3'd6, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 3'd6, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 3'd6, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 3'd6, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 3'd6, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 3'd6, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 3'd6, 3'd1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 3'd6, 3'd1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 3'd6, 3'd1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 3'd6, 3'd1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 3'd6, 3'd1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 3'd6, 3'd1, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 3'd6, 3'd2, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; sw_upc = 3'd5; auto_en = 1'b0; pause = 1'b0; step = 1'b0;
        tick();
        tick();
        check("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            auto_en = vecs[i].auto_en;
            sw_upc  = vecs[i].sw;
            tick();
            check($sformatf("vec%0d", i), vecs[i].upc, vecs[i].blank, vecs[i].active, vecs[i].wrap);
        end

        // Continue the lap: cycle n since enable shows code (n/6)%8, blanked in the last 2 of each 6.
        for (int n = 13; n <= 67; n++) begin
            tick();
            check($sformatf("lap n=%0d", n), 3'((n / 6) % 8), (n % 6) >= 4, 1'b1, n == 48);
        end

        // Pause on the second shown cycle of code 3 (n=67): hold 20 cycles.
        pause = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("hold k=%0d", k), 3'd3, 1'b0, 1'b1, 1'b0);
        end
        pause = 1'b0;
        tick(); check("resume1", 3'd3, 1'b0, 1'b1, 1'b0);
        tick(); check("resume2", 3'd3, 1'b0, 1'b1, 1'b0);
        tick(); check("resume_gap1", 3'd3, 1'b1, 1'b1, 1'b0);
        tick(); check("resume_gap2", 3'd3, 1'b1, 1'b1, 1'b0);
        tick(); check("resume_next", 3'd4, 1'b0, 1'b1, 1'b0);

        // Pause at code 4, single-step up to 7 and across the wrap.
        pause = 1'b1;
        tick(); check("hold4", 3'd4, 1'b0, 1'b1, 1'b0);
        for (int s = 5; s <= 8; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            check($sformatf("step->%0d", s % 8), 3'(s % 8), 1'b0, 1'b1, s == 8);
        end
        tick(); check("step_wrap_done", 3'd0, 1'b0, 1'b1, 1'b0);

        // Release; step pulses during SHOW (m=1) and GAP (m=4) must not disturb the sequence.
        pause = 1'b0;
        for (int m = 0; m <= 10; m++) begin
            step = (m == 1 || m == 4);
            tick();
            check($sformatf("steprun m=%0d", m), 3'(m / 6), (m % 6) >= 4, 1'b1, 1'b0);
        end
        step = 1'b0;

        // m=10 was a GAP cycle: reset mid-GAP.
        reset = 1'b1; sw_upc = 3'd6;
        tick(); check("reset_mid_gap", 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; auto_en = 1'b0;
        tick(); check("manual_after_reset", 3'd6, 1'b0, 1'b0, 1'b0);

        // auto_en dropped mid-SHOW.
        auto_en = 1'b1;
        tick(); check("auto_again0", 3'd0, 1'b0, 1'b1, 1'b0);
        tick(); check("auto_again1", 3'd0, 1'b0, 1'b1, 1'b0);
        auto_en = 1'b0; sw_upc = 3'd3;
        tick(); check("auto_off_mid_show", 3'd3, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
